// File: rtl/program_counter.sv
// Fetch-stage program counter: registers the upstream-selected next address,
// tracks the previous PC and flags misaligned targets. Optional hold via PC_STALL_EN.
module program_counter #(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PC_STALL_EN
  input  logic             stall,
`endif
  input  logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_prev,
  output logic             misalign
);

  localparam int unsigned ALIGN_W = 2;

  logic [WIDTH-1:0] pc_out_q,  pc_out_d;
  logic [WIDTH-1:0] pc_prev_q, pc_prev_d;
  logic             misalign_q, misalign_d;
  logic             update;

`ifdef PC_STALL_EN
  assign update = ~stall;
`else
  assign update = 1'b1;
`endif

  // Next-state: capture aligned target, shift old PC into pc_prev, flag low bits
  always_comb begin
    pc_out_d   = pc_out_q;
    pc_prev_d  = pc_prev_q;
    misalign_d = misalign_q;
    if (update) begin
      pc_prev_d  = pc_out_q;
      pc_out_d   = {pc_next[WIDTH-1:ALIGN_W], ALIGN_W'(0)};
      misalign_d = |pc_next[ALIGN_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out_q   <= RESET_VECTOR;
      pc_prev_q  <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      pc_out_q   <= pc_out_d;
      pc_prev_q  <= pc_prev_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_out   = pc_out_q;
  assign pc_prev  = pc_prev_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic model. Honours PC_STALL_EN.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic [31:0] pc_out, pc_prev;
  logic        misalign;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          run_chk = 1'b0;

  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_prev = 32'h0;
  logic        exp_mis = 1'b0;

  program_counter #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef PC_STALL_EN
    .stall    (stall),
`endif
    .pc_next  (pc_next),
    .pc_out   (pc_out),
    .pc_prev  (pc_prev),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: PC is the target rounded down to a word; misaligned if not a multiple of 4
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_pc   = 32'h0;
      exp_prev = 32'h0;
      exp_mis  = 1'b0;
    end else if (!stall) begin
      exp_prev = exp_pc;
      exp_pc   = (pc_next / 32'd4) * 32'd4;
      exp_mis  = (pc_next % 32'd4) != 32'd0;
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("model_pc_out",   pc_out,   exp_pc);
      chk("model_pc_prev",  pc_prev,  exp_prev);
      chk("model_misalign", {31'h0, misalign}, {31'h0, exp_mis});
    end
  end

  task automatic step(input logic [31:0] nxt);
    pc_next = nxt;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    run_chk = 1'b1;

    // Held in reset: edges must be ignored
    for (int i = 1; i <= 3; i++) begin
      step(32'(i * 4));
      chk("rst_hold_pc", pc_out, 32'h0);
      chk("rst_hold_prev", pc_prev, 32'h0);
      chk("rst_hold_mis", {31'h0, misalign}, 32'h0);
    end

    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(32'(i * 4));
      chk("seq_pc", pc_out, 32'(i * 4));
      chk("seq_prev", pc_prev, 32'((i - 1) * 4));
    end

    // Async reset mid-cycle while pc_out = 40
    pc_next = 32'd44;
    #2 reset = 1'b0;
    #1 chk("async_rst_pc", pc_out, 32'h0);
    chk("async_rst_prev", pc_prev, 32'h0);
    @(negedge clk);
    chk("async_rst_hold", pc_out, 32'h0);
    reset = 1'b1;

    step(32'h0000_0106);
    chk("mis_pc", pc_out, 32'h0000_0104);
    chk("mis_flag", {31'h0, misalign}, 32'h1);
    step(32'h0000_0200);
    chk("mis_clr_pc", pc_out, 32'h0000_0200);
    chk("mis_clr_flag", {31'h0, misalign}, 32'h0);

    step(32'hFFFF_FFFC);
    chk("wrap_hi", pc_out, 32'hFFFF_FFFC);
    step(32'h0000_0000);
    chk("wrap_lo", pc_out, 32'h0);
    chk("wrap_prev", pc_prev, 32'hFFFF_FFFC);

`ifdef PC_STALL_EN
    step(32'd4);
    step(32'd8);
    chk("stall_pre", pc_out, 32'd8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(32'h0000_0123 + 32'(i));
      chk("stall_hold_pc", pc_out, 32'd8);
      chk("stall_hold_prev", pc_prev, 32'd4);
    end
    stall = 1'b0;
    step(32'd12);
    chk("stall_release", pc_out, 32'd12);
    chk("stall_release_prev", pc_prev, 32'd8);
`endif

    // Randomized traffic with occasional async reset pulses and stalls
    for (int i = 0; i < 400; i++) begin
      reset = 1'b1;
`ifdef PC_STALL_EN
      stall = ($urandom_range(0, 3) == 0);
`endif
      pc_next = $urandom;
      if ($urandom_range(0, 29) == 0) begin
        #2 reset = 1'b0;
        #1 chk("rand_async_rst", pc_out, 32'h0);
      end
      @(negedge clk);
    end

    reset = 1'b1;
    stall = 1'b0;
    step(32'h0000_0010);
    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
